// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: func codes, FSM states, flag bundle
// and a sign-extension helper.
package alu_pkg;
  typedef logic [5:0] func_t;

  localparam func_t F_ADD  = 6'b100000;
  localparam func_t F_SUB  = 6'b100010;
  localparam func_t F_MULT = 6'b011000;
  localparam func_t F_DIV  = 6'b011010;
  localparam func_t F_AND  = 6'b100100;
  localparam func_t F_OR   = 6'b100101;
  localparam func_t F_NOR  = 6'b100111;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  typedef struct packed {
    logic overflow;
    logic equals;
    logic above;
    logic zero;
    logic div_zero;
    logic illegal;
  } flags_t;

  // Widest value the helper handles; a 2*WIDTH product must fit.
  localparam int MAX_W = 128;

  // Sign-extend the low w bits of v to the full MAX_W width.
  function automatic logic [MAX_W-1:0] sext(input logic [MAX_W-1:0] v, input int w);
    logic [MAX_W-1:0] t;
    t = v << (MAX_W - w);
    return $unsigned($signed(t) >>> (MAX_W - w));
  endfunction
endpackage

// File: rtl/alu_mc_if.sv
// Request/response bundle between the execute stage and the multi-cycle ALU.
interface alu_mc_if
  import alu_pkg::*;
#(parameter int WIDTH = 32);
  logic             in_valid, in_ready, out_valid, out_ready;
  logic [WIDTH-1:0] op1, op2, result, result_hi;
  func_t            func;
  logic             overflow, equals, above, zero, div_zero, illegal;

  modport master (
    output in_valid, op1, op2, func, out_ready,
    input  in_ready, out_valid, result, result_hi,
           overflow, equals, above, zero, div_zero, illegal
  );
  modport slave (
    input  in_valid, op1, op2, func, out_ready,
    output in_ready, out_valid, result, result_hi,
           overflow, equals, above, zero, div_zero, illegal
  );
endinterface

// File: rtl/alu_muldiv.sv
// Iterative signed multiply (shift-add) / divide (restoring) on magnitudes.
// done is asserted during the last iteration; lo/hi then carry the signed result.
module alu_muldiv
  import alu_pkg::*;
#(parameter int WIDTH = 32) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);
  localparam int CW = $clog2(WIDTH) + 1;

  logic               busy, div_q, neg_q, neg_r;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   acc, acc_n, q, q_n, m, sh;
  logic [WIDTH:0]     sum, diff;
  logic [2*WIDTH-1:0] prod;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  always_comb begin
    sum  = {1'b0, acc} + (q[0] ? {1'b0, m} : '0);
    // Remainder stays below |divisor| <= 2^(WIDTH-1), so its top bit is always 0.
    sh   = {acc[WIDTH-2:0], q[WIDTH-1]};
    diff = {1'b0, sh} - {1'b0, m};
    if (div_q) begin
      acc_n = diff[WIDTH] ? sh : diff[WIDTH-1:0];
      q_n   = {q[WIDTH-2:0], ~diff[WIDTH]};
    end else begin
      acc_n = sum[WIDTH:1];
      q_n   = {sum[0], q[WIDTH-1:1]};
    end
    prod = {acc_n, q_n};
    if (neg_q) prod = -prod;
    if (div_q) begin
      lo = neg_q ? -q_n : q_n;
      hi = neg_r ? -acc_n : acc_n;
    end else begin
      lo = prod[WIDTH-1:0];
      hi = prod[2*WIDTH-1:WIDTH];
    end
  end

  assign done = busy && (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      busy  <= 1'b0;
      cnt   <= '0;
      div_q <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      acc   <= '0;
      q     <= '0;
      m     <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      cnt   <= '0;
      div_q <= is_div;
      neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
      neg_r <= a[WIDTH-1];
      acc   <= '0;
      q     <= mag(a);
      m     <= mag(b);
    end else if (busy) begin
      acc <= acc_n;
      q   <= q_n;
      cnt <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end
endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU top: handshake FSM, single-cycle datapath and flag generation,
// with MULT/DIV delegated to the iterative engine.
module alu_mc
  import alu_pkg::*;
#(parameter int WIDTH = 32) (
  input logic     clk,
  input logic     rst,
  alu_mc_if.slave bus
);
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state;
  logic [WIDTH-1:0] op1_q, op2_q, sa, sb, r, rh, md_lo, md_hi;
  logic [WIDTH-1:0] result_q, result_hi_q;
  func_t            func_q, sf;
  flags_t           fl, flags_q;
  logic             in_ready_q, out_valid_q, accept, iter, md_done;

  assign accept = (state == IDLE) && bus.in_valid;
  assign iter   = (bus.func == F_MULT) || ((bus.func == F_DIV) && (bus.op2 != '0));
  // Live operands feed the datapath on accept; latched ones while iterating.
  assign sa = (state == IDLE) ? bus.op1  : op1_q;
  assign sb = (state == IDLE) ? bus.op2  : op2_q;
  assign sf = (state == IDLE) ? bus.func : func_q;

  alu_muldiv #(.WIDTH(WIDTH)) u_md (
    .clk    (clk),
    .rst    (rst),
    .start  (accept && iter),
    .is_div (bus.func == F_DIV),
    .a      (bus.op1),
    .b      (bus.op2),
    .done   (md_done),
    .lo     (md_lo),
    .hi     (md_hi)
  );

  always_comb begin
    r  = '0;
    rh = '0;
    fl = '0;
    case (sf)
      F_ADD: begin
        r = sa + sb;
        fl.overflow = (sa[WIDTH-1] == sb[WIDTH-1]) && (r[WIDTH-1] != sa[WIDTH-1]);
      end
      F_SUB: begin
        r = sa - sb;
        fl.overflow = (sa[WIDTH-1] != sb[WIDTH-1]) && (r[WIDTH-1] != sa[WIDTH-1]);
      end
      F_AND: r = sa & sb;
      F_OR:  r = sa | sb;
      F_NOR: r = ~(sa | sb);
      F_MULT: begin
        r  = md_lo;
        rh = md_hi;
        fl.overflow = sext(MAX_W'({md_hi, md_lo}), 2*WIDTH) != sext(MAX_W'(md_lo), WIDTH);
      end
      F_DIV: begin
        if (sb == '0) begin
          r  = '1;
          rh = sa;
          fl.overflow = 1'b1;
          fl.div_zero = 1'b1;
        end else begin
          r  = md_lo;
          rh = md_hi;
          fl.overflow = (sa == MIN) && (sb == '1);
        end
      end
      default: fl.illegal = 1'b1;
    endcase
    if (!fl.illegal) begin
      fl.equals = (sa == sb);
      fl.above  = $signed(sa) > $signed(sb);
      fl.zero   = (r == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
      flags_q     <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      func_q      <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          op1_q      <= bus.op1;
          op2_q      <= bus.op2;
          func_q     <= bus.func;
          in_ready_q <= 1'b0;
          if (iter) begin
            state <= CALC;
          end else begin
            state       <= DONE;
            out_valid_q <= 1'b1;
            result_q    <= r;
            result_hi_q <= rh;
            flags_q     <= fl;
          end
        end
        CALC: if (md_done) begin
          state       <= DONE;
          out_valid_q <= 1'b1;
          result_q    <= r;
          result_hi_q <= rh;
          flags_q     <= fl;
        end
        DONE: if (bus.out_ready) begin
          state       <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.result_hi = result_hi_q;
  assign bus.overflow  = flags_q.overflow;
  assign bus.equals    = flags_q.equals;
  assign bus.above     = flags_q.above;
  assign bus.zero      = flags_q.zero;
  assign bus.div_zero  = flags_q.div_zero;
  assign bus.illegal   = flags_q.illegal;
endmodule
